aes192_decrypt_iter: RTL and testbench

// - Iterative AES-192 inverse cipher (FIPS-197 InvCipher) computing one round per clock.
// - It is the decrypt counterpart of the combinational aes192 encrypt datapath.
// - Expands the 192-bit key on-chip into 13 round keys held in a register file.
// - Accepts ciphertext over a valid/ready handshake and returns plaintext over a valid/ready handshake.
// - Uses combinational inv_sub_bytes, inv_shift_rows and inv_mix_columns helpers.
// - SubWord in the key schedule uses the forward S-box.

---
 rtl/aes192_dec_if.sv | 23 ++
 rtl/aes192_decrypt_iter.sv | 197 +++++++++++++++++++
 tb/tb_aes192_decrypt_iter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes192_dec_if.sv
// Handshake bundle for the iterative AES-192 decryptor: key load, ciphertext in, plaintext out.
interface aes192_dec_if;
    logic         key_load;
    logic [191:0] key;
    logic         key_ready;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] cipher;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plain;
    logic         busy;

    modport master (
        output key_load, key, in_valid, cipher, out_ready,
        input  key_ready, in_ready, out_valid, plain, busy
    );

    modport slave (
        input  key_load, key, in_valid, cipher, out_ready,
        output key_ready, in_ready, out_valid, plain, busy
    );
endinterface

// File: rtl/aes192_decrypt_iter.sv
// Iterative AES-192 inverse cipher, one round per clock, with on-chip key expansion
// into a 52-word round-key file. S-boxes are computed arithmetically in GF(2^8).
module aes192_decrypt_iter (
    input  logic clk,
    input  logic rst_n,
    aes192_dec_if.slave bus
);
    localparam int unsigned NK     = 6;
    localparam int unsigned NR     = 12;
    localparam int unsigned KSTEPS = 8;
    localparam int unsigned NW     = 4 * (NR + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] KEXP = 2'd1;
    localparam logic [1:0] DEC  = 2'd2;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    logic [1:0]   state, state_nxt;
    logic [2:0]   step;
    logic [3:0]   rnd;
    logic [31:0]  kwin [NK];
    logic [31:0]  knew [NK];
    logic [31:0]  rk_w [NW];
    logic [127:0] st;
    logic [127:0] plain_q;
    logic         kready;
    logic         ovalid;
    logic         in_ready_c;
    logic         accept_c;
    logic [31:0]  sw_c;
    logic [127:0] rk_sel_c, rk12_c, rk0_c;
    logic [127:0] isb_c, imc_c;

    assign in_ready_c = (state == IDLE) && kready && !bus.key_load && (!ovalid || bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;

    assign bus.in_ready  = in_ready_c;
    assign bus.key_ready = kready;
    assign bus.out_valid = ovalid;
    assign bus.plain     = plain_q;
    assign bus.busy      = (state != IDLE);

    assign rk12_c   = {rk_w[48], rk_w[49], rk_w[50], rk_w[51]};
    assign rk0_c    = {rk_w[0], rk_w[1], rk_w[2], rk_w[3]};
    assign rk_sel_c = {rk_w[{rnd, 2'b00}], rk_w[{rnd, 2'b01}], rk_w[{rnd, 2'b10}], rk_w[{rnd, 2'b11}]};

    // One round of the inverse cipher on the current state.
    assign isb_c = inv_sub_bytes(inv_shift_rows(st));
    assign imc_c = inv_mix_columns(isb_c ^ rk_sel_c);

    // Six new schedule words from the previous six.
    always_comb begin
        sw_c = {sbox(kwin[NK-1][23:16]), sbox(kwin[NK-1][15:8]),
                sbox(kwin[NK-1][7:0]),   sbox(kwin[NK-1][31:24])}
               ^ {8'(8'h01 << step), 24'h0};
        knew[0] = kwin[0] ^ sw_c;
        for (int unsigned j = 1; j < NK; j++)
            knew[j] = kwin[j] ^ knew[j-1];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = DEC;
            KEXP:    if (step == 3'(KSTEPS - 1)) state_nxt = IDLE;
            DEC:     if (rnd == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.key_load) state_nxt = KEXP;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step    <= '0;
            rnd     <= '0;
            st      <= '0;
            plain_q <= '0;
            kready  <= 1'b0;
            ovalid  <= 1'b0;
            for (int unsigned j = 0; j < NK; j++) kwin[j] <= '0;
            for (int unsigned k = 0; k < NW; k++) rk_w[k] <= '0;
        end else if (bus.key_load) begin
            step   <= '0;
            kready <= 1'b0;
            ovalid <= 1'b0;
            for (int unsigned j = 0; j < NK; j++) begin
                kwin[j] <= bus.key[191 - 32*j -: 32];
                rk_w[j] <= bus.key[191 - 32*j -: 32];
            end
        end else begin
            if (ovalid && bus.out_ready) ovalid <= 1'b0;
            case (state)
                KEXP: begin
                    step <= step + 3'd1;
                    for (int unsigned j = 0; j < NK; j++) kwin[j] <= knew[j];
                    // Words beyond w51 fall outside the file and are dropped.
                    for (int unsigned k = NK; k < NW; k++)
                        if (32'(step) == k / NK - 1) rk_w[k] <= knew[k % NK];
                    if (step == 3'(KSTEPS - 1)) kready <= 1'b1;
                end
                IDLE: begin
                    if (accept_c) begin
                        st  <= bus.cipher ^ rk12_c;
                        rnd <= 4'(NR - 1);
                    end
                end
                DEC: begin
                    if (rnd == 4'd0) begin
                        plain_q <= isb_c ^ rk0_c;
                        ovalid  <= 1'b1;
                    end else begin
                        st  <= imc_c;
                        rnd <= rnd - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes192_decrypt_iter.sv
// Bench for aes192_decrypt_iter: FIPS-197 vectors, corner sequences and random blocks
// against a byte-array reference model of InvCipher.
module tb_aes192_decrypt_iter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes192_dec_if bus();
    aes192_decrypt_iter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [191:0] C2_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] C2_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C2_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [191:0] A2_KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

    logic [7:0]  sb  [256];
    logic [7:0]  isb [256];
    logic [31:0] mw  [52];

    typedef struct {
        logic [191:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // S-box generated by walking the multiplicative group with generator 3.
    function automatic void build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endfunction

    function automatic logic [7:0] mmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) if (b[i]) r = r ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (r[i]) r = r ^ (15'h11b << (i - 8));
        return r[7:0];
    endfunction

    function automatic void model_expand(input logic [191:0] k);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 6; i++) mw[i] = k[191 - 32*i -: 32];
        for (int i = 6; i < 52; i++) begin
            t = mw[i-1];
            if (i % 6 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = mmul(rc, 8'h02);
            end
            mw[i] = mw[i-6] ^ t;
        end
    endfunction

    function automatic logic [7:0] rkb(input int r, input int i);
        logic [31:0] w;
        w = mw[4*r + i/4];
        return w[31 - 8*(i%4) -: 8];
    endfunction

    function automatic logic [127:0] model_decrypt(input logic [127:0] c);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = c[127 - 8*i -: 8] ^ rkb(12, i);
        for (int r = 11; r >= 0; r--) begin
            for (int rr = 0; rr < 4; rr++)
                for (int cc = 0; cc < 4; cc++)
                    t[rr + 4*((cc + rr) % 4)] = s[rr + 4*cc];
            for (int i = 0; i < 16; i++) s[i] = isb[t[i]] ^ rkb(r, i);
            if (r > 0) begin
                for (int cc = 0; cc < 4; cc++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[4*cc + j];
                    s[4*cc+0] = mmul(a[0],8'h0e) ^ mmul(a[1],8'h0b) ^ mmul(a[2],8'h0d) ^ mmul(a[3],8'h09);
                    s[4*cc+1] = mmul(a[0],8'h09) ^ mmul(a[1],8'h0e) ^ mmul(a[2],8'h0b) ^ mmul(a[3],8'h0d);
                    s[4*cc+2] = mmul(a[0],8'h0d) ^ mmul(a[1],8'h09) ^ mmul(a[2],8'h0e) ^ mmul(a[3],8'h0b);
                    s[4*cc+3] = mmul(a[0],8'h0b) ^ mmul(a[1],8'h0d) ^ mmul(a[2],8'h09) ^ mmul(a[3],8'h0e);
                end
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [191:0] k);
        int n;
        bus.key_load = 1'b1;
        bus.key      = k;
        tick();
        bus.key_load = 1'b0;
        check("key_ready_after_load", 192'(bus.key_ready), 192'(0));
        n = 0;
        while (!bus.key_ready && n < 20) begin
            tick();
            n++;
        end
        check("key_latency", 192'(n), 192'(8));
        model_expand(k);
    endtask

    task automatic accept_block(input logic [127:0] c);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", 192'(bus.in_ready), 192'(1));
        bus.in_valid = 1'b1;
        bus.cipher   = c;
        tick();
        bus.in_valid = 1'b0;
        bus.cipher   = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", 192'(lat), 192'(12));
    endtask

    task automatic run_block(input logic [127:0] c, input int stall, output logic [127:0] got);
        int lat;
        bus.out_ready = 1'b0;
        accept_block(c);
        wait_out(lat);
        got = bus.plain;
        for (int s = 0; s < stall; s++) begin
            tick();
            check("stall_plain", 192'(bus.plain), 192'(got));
            check("stall_valid", 192'(bus.out_valid), 192'(1));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("retire", 192'(bus.out_valid), 192'(0));
    endtask

    initial begin
        logic [127:0] got, ct, pt;
        logic [191:0] k;
        int           lat;

        rst_n = 1'b0;
        bus.key_load = 1'b0; bus.key = '0; bus.in_valid = 1'b0;
        bus.cipher = '0; bus.out_ready = 1'b0;
        build_sbox();
        tick(); tick();
        rst_n = 1'b1;
        tick();

        check("rst_key_ready", 192'(bus.key_ready), 192'(0));
        check("rst_out_valid", 192'(bus.out_valid), 192'(0));
        check("rst_busy",      192'(bus.busy),      192'(0));
        check("rst_plain",     192'(bus.plain),     192'(0));
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_key_in_ready", 192'(bus.in_ready), 192'(0));
            check("no_key_busy",     192'(bus.busy),     192'(0));
        end
        bus.in_valid = 1'b0;

        // Table-driven vectors; only the C.2 row has a literal plaintext.
        tbl[0] = '{C2_KEY, C2_CT, C2_PT};
        tbl[1] = '{A2_KEY, C2_CT, '0};
        tbl[2] = '{192'h0, 128'h0, '0};
        tbl[3] = '{{6{32'hffffffff}}, 128'h0123456789abcdeffedcba9876543210, '0};
        for (int i = 1; i < 4; i++) begin
            model_expand(tbl[i].key);
            tbl[i].pt = model_decrypt(tbl[i].ct);
        end
        model_expand(C2_KEY);
        check("model_c2", 192'(model_decrypt(C2_CT)), 192'(C2_PT));

        for (int i = 0; i < 4; i++) begin
            load_key(tbl[i].key);
            if (i == 0)
                check("c2_rk12", 192'({dut.rk_w[48], dut.rk_w[49], dut.rk_w[50], dut.rk_w[51]}),
                      192'(128'ha4970a331a78dc09c418c271e3a41d5d));
            if (i == 1) check("a2_w51", 192'(dut.rk_w[51]), 192'(32'h01002202));
            run_block(tbl[i].ct, i, got);
            check("table_plain", 192'(got), 192'(tbl[i].pt));
        end

        // Backpressure, then retire-and-accept on the same edge.
        load_key(C2_KEY);
        accept_block(C2_CT);
        wait_out(lat);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_plain",    192'(bus.plain),     192'(C2_PT));
            check("bp_valid",    192'(bus.out_valid), 192'(1));
            check("bp_in_ready", 192'(bus.in_ready),  192'(0));
        end
        ct = 128'h00000000000000000000000000000001;
        pt = model_decrypt(ct);
        bus.in_valid = 1'b1; bus.cipher = ct; bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_up", 192'(bus.in_ready), 192'(1));
        tick();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        check("bp_retired", 192'(bus.out_valid), 192'(0));
        check("bp_busy",    192'(bus.busy),      192'(1));
        wait_out(lat);
        check("bp_next_plain", 192'(bus.plain), 192'(pt));
        bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;

        // key_load at A5 aborts the decrypt.
        accept_block(C2_CT);
        for (int i = 0; i < 4; i++) tick();
        bus.key_load = 1'b1; bus.key = C2_KEY;
        tick();
        bus.key_load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("abort_key_ready", 192'(bus.key_ready), 192'(0));
            check("abort_out_valid", 192'(bus.out_valid), 192'(0));
            tick();
        end
        check("abort_key_ready_up", 192'(bus.key_ready), 192'(1));
        check("abort_no_output",    192'(bus.out_valid), 192'(0));
        run_block(C2_CT, 0, got);
        check("abort_redecrypt", 192'(got), 192'(C2_PT));

        // key_load during expansion restarts it.
        bus.key_load = 1'b1; bus.key = A2_KEY;
        tick();
        bus.key_load = 1'b0;
        tick(); tick(); tick();
        load_key(C2_KEY);
        run_block(C2_CT, 1, got);
        check("restart_plain", 192'(got), 192'(C2_PT));

        // Reset in the middle of a decrypt.
        accept_block(C2_CT);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_key_ready", 192'(bus.key_ready), 192'(0));
        check("mrst_out_valid", 192'(bus.out_valid), 192'(0));
        check("mrst_busy",      192'(bus.busy),      192'(0));
        check("mrst_plain",     192'(bus.plain),     192'(0));
        bus.in_valid = 1'b1; bus.cipher = C2_CT;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mrst_in_ready",  192'(bus.in_ready),  192'(0));
            check("mrst_no_output", 192'(bus.out_valid), 192'(0));
        end
        bus.in_valid = 1'b0;
        load_key(C2_KEY);
        run_block(C2_CT, 0, got);
        check("mrst_plain_after", 192'(got), 192'(C2_PT));

        // Random keys and blocks with random output stalls.
        for (int it = 0; it < 200; it++) begin
            k  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            ct = {$urandom(), $urandom(), $urandom(), $urandom()};
            load_key(k);
            pt = model_decrypt(ct);
            run_block(ct, int'($urandom_range(0, 3)), got);
            check("rand_plain", 192'(got), 192'(pt));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
